// File: rtl/comp_scheduler_pkg.sv
// comp_scheduler_pkg: shared FSM encodings, component ids and default sizes for the component scheduler
package comp_scheduler_pkg;
  localparam int SWIDTH = 2;
  localparam logic [SWIDTH-1:0] S_OFF = 2'b00;
  localparam logic [SWIDTH-1:0] S_A   = 2'b01;
  localparam logic [SWIDTH-1:0] S_B   = 2'b10;
  localparam logic [SWIDTH-1:0] S_C   = 2'b11;
  localparam logic [1:0] ID_AIRFLOW   = 2'b00;
  localparam logic [1:0] ID_THRUSTERS = 2'b01;
  localparam logic [1:0] ID_SOLAR     = 2'b10;
  localparam int N_DEF  = 3;
  localparam int DW_DEF = 64;
endpackage

// File: rtl/comp_scheduler_if.sv
// comp_scheduler_if: requester and shared message channel bundle
//   req/payload/ack : per-component request, payload slices, one-cycle grant pulse
//   msg_*           : shared valid/ready message channel toward the io layer
//   master = scheduler side, slave = requesters plus channel consumer
interface comp_scheduler_if
  import comp_scheduler_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
);
  logic [N-1:0]    req;
  logic [N*DW-1:0] payload;
  logic [N-1:0]    ack;
  logic            msg_valid;
  logic            msg_ready;
  logic [1:0]      msg_id;
  logic [DW-1:0]   msg_data;
  modport master (input req, payload, msg_ready, output ack, msg_valid, msg_id, msg_data);
  modport slave  (output req, payload, msg_ready, input ack, msg_valid, msg_id, msg_data);
endinterface

// File: rtl/comp_scheduler_rr_picker.sv
// comp_scheduler_rr_picker: combinational round-robin pick of the first eligible index at or after ptr_i
//   eligible_i : per-requester eligibility
//   ptr_i      : round-robin start index
//   grant_o    : chosen index, any_o : at least one eligible
module comp_scheduler_rr_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0] eligible_i,
  input  logic [1:0]   ptr_i,
  output logic [1:0]   grant_o,
  output logic         any_o
);
  always_comb begin
    grant_o = '0;
    any_o   = |eligible_i;
    // lowest eligible overall is the wrap-around fallback; lowest at/after ptr overrides it
    for (int i = N - 1; i >= 0; i--)
      if (eligible_i[i]) grant_o = 2'(i);
    for (int i = N - 1; i >= 0; i--)
      if (eligible_i[i] && i >= int'(ptr_i)) grant_o = 2'(i);
  end
endmodule

// File: rtl/comp_scheduler.sv
// comp_scheduler: power sequencing of station components plus round-robin message arbitration
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : request system on (1) / off (0)
//   bus        : requester and shared message channel (master side)
//   en_o       : per-component enable
//   state_o    : current FSM state
module comp_scheduler
  import comp_scheduler_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DW      = DW_DEF,
  parameter int HOLD    = 100,
  parameter int STAGGER = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  comp_scheduler_if.master   bus,
  output logic [N-1:0]       en_o,
  output logic [SWIDTH-1:0]  state_o
);
  localparam int HW = $clog2(HOLD + 1);
  localparam int TW = $clog2(STAGGER + 1);
  logic [SWIDTH-1:0] state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     stag_q, stag_d;
  logic [N-1:0]      en_q, en_d, ack_q, ack_d, elig;
  logic [1:0]        ptr_q, ptr_d, id_q, id_d, g;
  logic              mv_q, mv_d, any, free, win;
  logic [DW-1:0]     data_q, data_d;
  logic [DW-1:0]     pl [N];
  for (genvar i = 0; i < N; i++) begin : g_pl
    assign pl[i] = bus.payload[i*DW +: DW];
  end
  assign elig = bus.req & en_q & {N{state_q == S_A || state_q == S_B}};
  assign free = !mv_q || bus.msg_ready;
  assign win  = free && any;
  comp_scheduler_rr_picker #(.N(N)) u_pick (
    .eligible_i (elig),
    .ptr_i      (ptr_q),
    .grant_o    (g),
    .any_o      (any)
  );
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    stag_d  = stag_q;
    en_d    = en_q;
    if (state_q == S_OFF) begin
      en_d   = '0;
      stag_d = '0;
      hold_d = start_i ? hold_q + 1'b1 : '0;
      if (start_i && hold_q == HW'(HOLD - 1)) begin
        state_d = S_A;
        hold_d  = '0;
      end
    end else if (state_q == S_A) begin
      // enables fill from bit 0 upward; the first S_A edge sets en[0] immediately
      if (!start_i) state_d = S_C;
      else if (en_q[N-1]) state_d = S_B;
      else if (en_q == '0 || stag_q == TW'(STAGGER - 1)) begin
        en_d   = (en_q << 1) | N'(1);
        stag_d = '0;
      end else stag_d = stag_q + 1'b1;
    end else if (state_q == S_B) state_d = start_i ? S_B : S_C;
    else if (free) begin
      // halt completes once any in-flight message has been accepted
      state_d = S_OFF;
      en_d    = '0;
    end
  end
  assign mv_d   = free ? any : mv_q;
  assign id_d   = win ? g : id_q;
  assign data_d = win ? pl[g] : data_q;
  assign ack_d  = win ? N'(1) << g : '0;
  assign ptr_d  = win ? (g == 2'(N - 1) ? 2'd0 : g + 2'd1) : ptr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      hold_q  <= '0;
      stag_q  <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      ptr_q   <= '0;
      mv_q    <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      mv_q    <= mv_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end
  assign en_o          = en_q;
  assign state_o       = state_q;
  assign bus.ack       = ack_q;
  assign bus.msg_valid = mv_q;
  assign bus.msg_id    = id_q;
  assign bus.msg_data  = data_q;
endmodule
